// File: rtl/operand_loader_if.sv
// Bus between the operand loader and the board/ALU side.
interface operand_loader_if;
  logic [7:0]  sw;
  logic        cin_sw;
  logic        btn_enter;
  logic        btn_clr;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [15:0] R1;
  logic [15:0] R2;
  logic [7:0]  opcode;
  logic        cin;
  logic [15:0] result;
  logic [4:0]  flags;
  logic        valid;
  logic [2:0]  state;
  logic [15:0] disp_value;

  // Board/ALU side: drives switches, buttons and ALU results.
  modport master (
    output sw, cin_sw, btn_enter, btn_clr, alu_result, alu_flags,
    input  R1, R2, opcode, cin, result, flags, valid, state, disp_value
  );

  // Loader side.
  modport slave (
    input  sw, cin_sw, btn_enter, btn_clr, alu_result, alu_flags,
    output R1, R2, opcode, cin, result, flags, valid, state, disp_value
  );
endinterface

// File: rtl/operand_loader.sv
// Button-driven operand entry: debounced enter/clear step an FSM that loads
// R1, R2, opcode and cin, then latches the ALU result for display.
module operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic             clk,
  input logic             rst_n,
  operand_loader_if.slave bus
);

  localparam int unsigned NBTN      = 2;
  localparam int unsigned BTN_ENTER = 0;
  localparam int unsigned BTN_CLR   = 1;
  localparam int unsigned CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_R1_LO = 3'd0,
    S_R1_HI = 3'd1,
    S_R2_LO = 3'd2,
    S_R2_HI = 3'd3,
    S_OP    = 3'd4,
    S_EXEC  = 3'd5,
    S_SHOW  = 3'd6
  } state_e;

  logic [NBTN-1:0]            btn_raw;
  logic [NBTN-1:0]            sync1_q, sync2_q;
  logic [NBTN-1:0]            level_q, level_d;
  logic [NBTN-1:0]            armed_q, armed_d;
  logic [NBTN-1:0]            evt_q, evt_d;
  logic [NBTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]                 cin_sync_q;

  state_e      state_q, state_d;
  logic [15:0] r1_q, r1_d, r2_q, r2_d, result_q, result_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        cin_q, cin_d, valid_q, valid_d;
  logic [4:0]  flags_q, flags_d;
  logic [15:0] disp_c;
  logic        enter_c, clr_c;

  assign btn_raw = {bus.btn_clr, bus.btn_enter};

  // Two-flop synchronizers for the asynchronous buttons and carry switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cin_sync_q <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      cin_sync_q <= {cin_sync_q[0], bus.cin_sw};
    end
  end

  // Debounce: a button must first be seen released for a full window after
  // reset (arming), so a button held through reset never yields an event.
  always_comb begin
    level_d = level_q;
    armed_d = armed_q;
    evt_d   = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < NBTN; i++) begin
      if (!armed_q[i]) begin
        if (sync2_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = '0;
          armed_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = '0;
          level_d[i] = sync2_q[i];
          evt_d[i]   = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debouncer state registers; evt_q is the one-cycle press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      armed_q <= '0;
      evt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      armed_q <= armed_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign enter_c = evt_q[BTN_ENTER];
  assign clr_c   = evt_q[BTN_CLR];

  // Next-state and register-load logic; clear overrides enter.
  always_comb begin
    state_d  = state_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    opcode_d = opcode_q;
    cin_d    = cin_q;
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = valid_q;
    if (clr_c) begin
      state_d  = S_R1_LO;
      r1_d     = '0;
      r2_d     = '0;
      opcode_d = '0;
      cin_d    = 1'b0;
      result_d = '0;
      flags_d  = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        S_R1_LO: if (enter_c) begin r1_d = {8'h00, bus.sw};   state_d = S_R1_HI; end
        S_R1_HI: if (enter_c) begin r1_d[15:8] = bus.sw;      state_d = S_R2_LO; end
        S_R2_LO: if (enter_c) begin r2_d = {8'h00, bus.sw};   state_d = S_R2_HI; end
        S_R2_HI: if (enter_c) begin r2_d[15:8] = bus.sw;      state_d = S_OP;    end
        S_OP: if (enter_c) begin
          opcode_d = bus.sw;
          cin_d    = cin_sync_q[1];
          state_d  = S_EXEC;
        end
        S_EXEC: begin
          result_d = bus.alu_result;
          flags_d  = bus.alu_flags;
          valid_d  = 1'b1;
          state_d  = S_SHOW;
        end
        S_SHOW: if (enter_c) begin valid_d = 1'b0; state_d = S_R1_LO; end
        default: state_d = S_R1_LO;
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_R1_LO;
      r1_q     <= '0;
      r2_q     <= '0;
      opcode_q <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      opcode_q <= opcode_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  // Display source selected by the registered state.
  always_comb begin
    disp_c = 16'h0000;
    case (state_q)
      S_R1_LO, S_R1_HI: disp_c = r1_q;
      S_R2_LO, S_R2_HI: disp_c = r2_q;
      S_OP, S_EXEC:     disp_c = {8'h00, opcode_q};
      S_SHOW:           disp_c = result_q;
      default:          disp_c = 16'h0000;
    endcase
  end

  assign bus.R1         = r1_q;
  assign bus.R2         = r2_q;
  assign bus.opcode     = opcode_q;
  assign bus.cin        = cin_q;
  assign bus.result     = result_q;
  assign bus.flags      = flags_q;
  assign bus.valid      = valid_q;
  assign bus.state      = 3'(state_q);
  assign bus.disp_value = disp_c;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with an adder standing in for the ALU.
module tb_operand_loader;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;
  int   last_lat;
  logic [2:0] last_first;

  operand_loader_if bus ();

  operand_loader #(.DEBOUNCE_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.alu_result = bus.R1 + bus.R2;
  assign bus.alu_flags  = {bus.cin, bus.opcode[3:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Hold the chosen buttons 40 cycles, release for 40; record first state change.
  task automatic press(input bit use_enter, input bit use_clr);
    logic [2:0] s0;
    s0         = bus.state;
    last_lat   = 0;
    last_first = s0;
    bus.btn_enter = use_enter;
    bus.btn_clr   = use_clr;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (last_lat == 0 && bus.state !== s0) begin
        last_lat   = k;
        last_first = bus.state;
      end
    end
    bus.btn_enter = 1'b0;
    bus.btn_clr   = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic enter(input logic [7:0] v);
    bus.sw = v;
    press(1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sw = 8'h00;
    bus.cin_sw = 1'b0;
    bus.btn_enter = 1'b0;
    bus.btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_R1", 32'(bus.R1), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_disp", 32'(bus.disp_value), 32'h0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    // Full operation 0x0001 + 0x7FFF
    enter(8'h01);
    check("lat_in_range", 32'(last_lat >= 18 && last_lat <= 20), 32'd1);
    check("r1lo_state", 32'(bus.state), 32'd1);
    check("r1lo_R1", 32'(bus.R1), 32'h0001);
    enter(8'h00);
    check("r1hi_state", 32'(bus.state), 32'd2);
    enter(8'hFF);
    check("r2lo_R2", 32'(bus.R2), 32'h00FF);
    check("r2lo_disp", 32'(bus.disp_value), 32'h00FF);
    enter(8'h7F);
    check("r2hi_state", 32'(bus.state), 32'd4);
    check("r2hi_R2", 32'(bus.R2), 32'h7FFF);
    bus.cin_sw = 1'b0;
    enter(8'h01);
    check("exec_seen", 32'(last_first), 32'd5);
    check("show_state", 32'(bus.state), 32'd6);
    check("show_R1", 32'(bus.R1), 32'h0001);
    check("show_opcode", 32'(bus.opcode), 32'h01);
    check("show_result", 32'(bus.result), 32'h8000);
    check("show_flags", 32'(bus.flags), 32'h01);
    check("show_valid", 32'(bus.valid), 32'd1);
    check("show_disp", 32'(bus.disp_value), 32'h8000);

    // Wrap back to R1_LO: result retained, valid dropped
    enter(8'h55);
    check("wrap_state", 32'(bus.state), 32'd0);
    check("wrap_valid", 32'(bus.valid), 32'd0);
    check("wrap_result", 32'(bus.result), 32'h8000);
    check("wrap_disp", 32'(bus.disp_value), 32'h0001);

    // Bounce: five 3-cycle pulses must not register
    bus.sw = 8'hAA;
    for (int p = 0; p < 5; p++) begin
      bus.btn_enter = 1'b1;
      repeat (3) @(negedge clk);
      bus.btn_enter = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    check("bounce_state", 32'(bus.state), 32'd0);
    check("bounce_R1", 32'(bus.R1), 32'h0001);
    enter(8'hAA);
    check("clean_state", 32'(bus.state), 32'd1);
    check("clean_R1", 32'(bus.R1), 32'h00AA);

    // Clear mid-entry in R2_HI with R1=1234
    bus.sw = 8'h00;
    press(1'b0, 1'b1);
    check("clr1_state", 32'(bus.state), 32'd0);
    enter(8'h34);
    enter(8'h12);
    enter(8'h05);
    check("pre_clr_state", 32'(bus.state), 32'd3);
    check("pre_clr_R1", 32'(bus.R1), 32'h1234);
    press(1'b0, 1'b1);
    check("clr_lat", 32'(last_lat >= 18 && last_lat <= 20), 32'd1);
    check("clr_state", 32'(bus.state), 32'd0);
    check("clr_R1", 32'(bus.R1), 32'h0000);
    check("clr_R2", 32'(bus.R2), 32'h0000);
    check("clr_valid", 32'(bus.valid), 32'd0);
    check("clr_disp", 32'(bus.disp_value), 32'h0000);

    // Enter and clear together in OP: clear wins
    enter(8'h01);
    enter(8'h00);
    enter(8'hFF);
    enter(8'h7F);
    check("op_state", 32'(bus.state), 32'd4);
    bus.sw = 8'h5A;
    press(1'b1, 1'b1);
    check("simul_state", 32'(bus.state), 32'd0);
    check("simul_opcode", 32'(bus.opcode), 32'h00);
    check("simul_R1", 32'(bus.R1), 32'h0000);

    // Reset in SHOW with enter held through and after reset
    enter(8'h01);
    enter(8'h00);
    enter(8'hFF);
    enter(8'h7F);
    bus.cin_sw = 1'b1;
    enter(8'h01);
    check("show2_result", 32'(bus.result), 32'h8000);
    check("show2_cin", 32'(bus.cin), 32'd1);
    check("show2_flags", 32'(bus.flags), 32'h11);
    bus.btn_enter = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_state", 32'(bus.state), 32'd0);
    check("rst2_R1", 32'(bus.R1), 32'h0);
    check("rst2_R2", 32'(bus.R2), 32'h0);
    check("rst2_opcode", 32'(bus.opcode), 32'h0);
    check("rst2_cin", 32'(bus.cin), 32'd0);
    check("rst2_result", 32'(bus.result), 32'h0);
    check("rst2_flags", 32'(bus.flags), 32'h0);
    check("rst2_valid", 32'(bus.valid), 32'd0);
    check("rst2_disp", 32'(bus.disp_value), 32'h0);
    rst_n = 1'b1;
    bus.sw = 8'h66;
    repeat (60) @(negedge clk);
    check("held_state", 32'(bus.state), 32'd0);
    check("held_R1", 32'(bus.R1), 32'h0);
    bus.btn_enter = 1'b0;
    repeat (40) @(negedge clk);
    enter(8'h77);
    check("repress_state", 32'(bus.state), 32'd1);
    check("repress_R1", 32'(bus.R1), 32'h0077);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
